// File: rtl/seq_stream_loader_if.sv
// Beat-stream and result bundle between the input interface, the loader and the scoring array.
// master drives the load controls and beats; slave is the loader itself.
interface seq_stream_loader_if #(
  parameter int NUM_CH       = 2,
  parameter int LETTER_WIDTH = 2,
  parameter int SEQ_LENGTH   = 32,
  parameter int INPUT_WIDTH  = 8
);
  localparam int LEN_W = $clog2(SEQ_LENGTH + 1);

  logic                                     start;
  logic [LEN_W-1:0]                         seq_len;
  logic                                     abort;
  logic                                     in_valid;
  logic                                     in_ready;
  logic [NUM_CH*INPUT_WIDTH-1:0]            in_data;
  logic [NUM_CH*SEQ_LENGTH*LETTER_WIDTH-1:0] seq_out;
  logic [LEN_W-1:0]                         seq_len_out;
  logic                                     out_valid;
  logic                                     out_release;
  logic                                     err;

  modport master (
    output start, seq_len, abort, in_valid, in_data, out_release,
    input  in_ready, seq_out, seq_len_out, out_valid, err
  );

  modport slave (
    input  start, seq_len, abort, in_valid, in_data, out_release,
    output in_ready, seq_out, seq_len_out, out_valid, err
  );
endinterface

// File: rtl/seq_stream_loader.sv
// Loads NUM_CH letter sequences in lockstep from a valid/ready beat stream and holds
// the result for the scoring array until it is released or aborted.
module seq_stream_loader #(
  parameter int NUM_CH       = 2,
  parameter int LETTER_WIDTH = 2,
  parameter int SEQ_LENGTH   = 32,
  parameter int INPUT_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst,
  seq_stream_loader_if.slave bus
);
  localparam int LPB      = INPUT_WIDTH / LETTER_WIDTH;
  localparam int NUM_REGS = SEQ_LENGTH / LPB;
  localparam int LEN_W    = $clog2(SEQ_LENGTH + 1);
  localparam int CNT_W    = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t                 state_q, state_d;
  logic [INPUT_WIDTH-1:0] regs_q [NUM_CH][NUM_REGS];
  logic [INPUT_WIDTH-1:0] regs_d [NUM_CH][NUM_REGS];
  logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]       beats_needed_q, beats_needed_d;
  logic [LEN_W-1:0]       seq_len_q, seq_len_d;
  logic                   err_q, err_d;

  logic                   len_legal;
  logic [LEN_W:0]         len_round;
  logic [CNT_W-1:0]       beats_for_len;
  logic [LEN_W:0]         k_idx;
  logic [INPUT_WIDTH-1:0] masked_beat [NUM_CH];

  assign len_legal     = (bus.seq_len != '0) && (bus.seq_len <= LEN_W'(SEQ_LENGTH));
  assign len_round     = {1'b0, bus.seq_len} + (LEN_W+1)'(LPB - 1);
  assign beats_for_len = CNT_W'(len_round / (LEN_W+1)'(LPB));

  // Letters past the latched length are zeroed so the array never sees stale tails.
  always_comb begin
    k_idx = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      masked_beat[c] = '0;
      for (int j = 0; j < LPB; j++) begin
        k_idx = (LEN_W+1)'(beat_cnt_q) * (LEN_W+1)'(LPB) + (LEN_W+1)'(j);
        if (k_idx < {1'b0, seq_len_q}) begin
          masked_beat[c][j*LETTER_WIDTH +: LETTER_WIDTH] =
            bus.in_data[c*INPUT_WIDTH + j*LETTER_WIDTH +: LETTER_WIDTH];
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    regs_d         = regs_q;
    beat_cnt_d     = beat_cnt_q;
    beats_needed_d = beats_needed_q;
    seq_len_d      = seq_len_q;
    err_d          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_legal) begin
            regs_d         = '{default: '0};
            seq_len_d      = bus.seq_len;
            beats_needed_d = beats_for_len;
            beat_cnt_d     = '0;
            state_d        = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD: begin
        if (bus.abort) begin
          regs_d         = '{default: '0};
          beat_cnt_d     = '0;
          beats_needed_d = '0;
          seq_len_d      = '0;
          state_d        = IDLE;
        end else begin
          err_d = bus.start;
          if (bus.in_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
              for (int r = 0; r < NUM_REGS; r++) begin
                if (CNT_W'(r) == beat_cnt_q) begin
                  regs_d[c][r] = masked_beat[c];
                end
              end
            end
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (beat_cnt_q == beats_needed_q - CNT_W'(1)) begin
              state_d = FULL;
            end
          end
        end
      end

      FULL: begin
        if (bus.abort) begin
          regs_d         = '{default: '0};
          beat_cnt_d     = '0;
          beats_needed_d = '0;
          seq_len_d      = '0;
          state_d        = IDLE;
        end else begin
          err_d = bus.start;
          if (bus.out_release) begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      regs_q         <= '{default: '0};
      beat_cnt_q     <= '0;
      beats_needed_q <= '0;
      seq_len_q      <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      regs_q         <= regs_d;
      beat_cnt_q     <= beat_cnt_d;
      beats_needed_q <= beats_needed_d;
      seq_len_q      <= seq_len_d;
      err_q          <= err_d;
    end
  end

  always_comb begin
    bus.seq_out = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        bus.seq_out[(c*NUM_REGS + r)*INPUT_WIDTH +: INPUT_WIDTH] = regs_q[c][r];
      end
    end
  end

  assign bus.in_ready    = (state_q == LOAD);
  assign bus.out_valid   = (state_q == FULL);
  assign bus.seq_len_out = seq_len_q;
  assign bus.err         = err_q;
endmodule
